// File: rtl/int_dispatch.sv
// int_dispatch: services the 8-source interrupt controller over its Wishbone
// register port and hands the highest-priority pending source to the CPU.
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   irq_i            : controller int request (only looked at while idle)
//   irq_ack_o        : one-cycle pulse to the controller ins_ack
//   o_wb_cyc/adr/we  : Wishbone master strobes (adr 0 = status, 1 = IE)
//   o_wb_dat         : write data (status with the serviced bit cleared)
//   i_wb_rdt/i_wb_ack: read data and slave acknowledge
//   cpu_irq_o        : vector valid, held until cpu_ack_i
//   cpu_vec_o        : serviced source index, 0 = int1
//   cpu_ack_i        : CPU accepted the vector
//   busy_o           : sequence in progress
//   err_o            : sticky bus-timeout flag
module int_dispatch #(
    parameter int NSRC       = 8,
    parameter int VW         = 3,
    parameter int WB_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq_i,
    output logic            irq_ack_o,
    output logic            o_wb_cyc,
    output logic            o_wb_adr,
    output logic            o_wb_we,
    output logic [NSRC-1:0] o_wb_dat,
    input  logic [NSRC-1:0] i_wb_rdt,
    input  logic            i_wb_ack,
    output logic            cpu_irq_o,
    output logic [VW-1:0]   cpu_vec_o,
    input  logic            cpu_ack_i,
    output logic            busy_o,
    output logic            err_o
);

    localparam int TW = $clog2(WB_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        RD_ST,
        GAP1,
        RD_IE,
        GAP2,
        PICK,
        WR_ST,
        ACKI,
        PRESENT
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [NSRC-1:0] st;
    logic [NSRC-1:0] ie;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] wr_dat;
    logic [VW-1:0]   pick_idx;
    logic [TW-1:0]   tcnt;
    logic            tmo;

    assign pend = st & ie;

    // Lowest set bit wins: scan downwards so the last hit is the lowest.
    always_comb begin
        pick_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pick_idx = VW'(i);
            end
        end
    end

    assign wr_dat = st & ~(NSRC'(1) << pick_idx);

    // Fires on the WB_TIMEOUT-th consecutive cyc cycle without ack.
    assign tmo = o_wb_cyc && !i_wb_ack &&
                 (tcnt == TW'(WB_TIMEOUT - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (irq_i) state_n = RD_ST;
            RD_ST: begin
                if (tmo)           state_n = IDLE;
                else if (i_wb_ack) state_n = GAP1;
            end
            GAP1:    state_n = RD_IE;
            RD_IE: begin
                if (tmo)           state_n = IDLE;
                else if (i_wb_ack) state_n = GAP2;
            end
            GAP2:    state_n = PICK;
            PICK:    state_n = (pend == '0) ? IDLE : WR_ST;
            WR_ST: begin
                if (tmo)           state_n = IDLE;
                else if (i_wb_ack) state_n = ACKI;
            end
            ACKI:    state_n = PRESENT;
            PRESENT: if (cpu_ack_i) state_n = RD_ST;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            st        <= '0;
            ie        <= '0;
            tcnt      <= '0;
            irq_ack_o <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_adr  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_dat  <= '0;
            cpu_irq_o <= 1'b0;
            cpu_vec_o <= '0;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state    <= state_n;
            o_wb_cyc <= (state_n == RD_ST) || (state_n == RD_IE) ||
                        (state_n == WR_ST);
            o_wb_adr <= (state_n == RD_IE);
            o_wb_we  <= (state_n == WR_ST);
            busy_o   <= (state_n != IDLE);
            cpu_irq_o <= (state_n == PRESENT);
            // The drained/spurious ack is issued during PICK itself so
            // the controller can drop int before IDLE samples it again.
            irq_ack_o <= (state_n == ACKI) ||
                         ((state == GAP2) && (pend == '0));
            err_o    <= err_o | tmo;

            if (o_wb_cyc && !i_wb_ack && !tmo) begin
                tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
            end

            if ((state == RD_ST) && i_wb_ack) begin
                st <= i_wb_rdt;
            end
            if ((state == RD_IE) && i_wb_ack) begin
                ie <= i_wb_rdt;
            end

            if ((state == PICK) && (pend != '0)) begin
                cpu_vec_o <= pick_idx;
                o_wb_dat  <= wr_dat;
            end else if (state_n != WR_ST) begin
                o_wb_dat  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_int_dispatch.sv
// tb_int_dispatch: directed and randomized checks of int_dispatch against a
// small controller/slave model and a per-source priority model.
module tb_int_dispatch;

    localparam int NSRC = 8;
    localparam int VW   = 3;
    localparam int TMO  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            irq_i;
    logic            irq_ack_o;
    logic            o_wb_cyc;
    logic            o_wb_adr;
    logic            o_wb_we;
    logic [NSRC-1:0] o_wb_dat;
    logic [NSRC-1:0] rdt;
    logic            s_ack;
    logic            cpu_irq_o;
    logic [VW-1:0]   cpu_vec_o;
    logic            cpu_ack_i;
    logic            busy_o;
    logic            err_o;

    // Controller register model.
    logic [NSRC-1:0] s_st;
    logic [NSRC-1:0] s_ie;
    logic [NSRC-1:0] src_pulse;
    logic            s_clr;
    logic            s_hang;
    logic [NSRC-1:0] wr_q[$];

    int total = 0;
    int bad   = 0;

    logic [VW-1:0] vec_q[$];
    int            vec_cyc[$];
    int            ack_cyc[$];
    logic [8:0]    rd_q[$];
    int            wr_base;

    always #5 clk = ~clk;

    int_dispatch #(
        .NSRC(NSRC),
        .VW(VW),
        .WB_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq_i(irq_i),
        .irq_ack_o(irq_ack_o),
        .o_wb_cyc(o_wb_cyc),
        .o_wb_adr(o_wb_adr),
        .o_wb_we(o_wb_we),
        .o_wb_dat(o_wb_dat),
        .i_wb_rdt(rdt),
        .i_wb_ack(s_ack),
        .cpu_irq_o(cpu_irq_o),
        .cpu_vec_o(cpu_vec_o),
        .cpu_ack_i(cpu_ack_i),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    // One-cycle slave whose ack toggles while cyc stays high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ack <= 1'b0;
            s_st  <= '0;
            rdt   <= '0;
        end else begin
            s_ack <= o_wb_cyc && !s_ack && !s_hang;
            if (o_wb_cyc && !s_ack) rdt <= o_wb_adr ? s_ie : s_st;
            if (s_clr) begin
                s_st <= '0;
            end else if (o_wb_cyc && o_wb_we && s_ack) begin
                s_st <= o_wb_dat | src_pulse;
                wr_q.push_back(o_wb_dat);
            end else begin
                s_st <= s_st | src_pulse;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_status();
        @(negedge clk);
        s_clr = 1'b1;
        @(negedge clk);
        s_clr = 1'b0;
    endtask

    task automatic pulse_src(input logic [NSRC-1:0] bits);
        src_pulse = bits;
        @(negedge clk);
        src_pulse = '0;
    endtask

    // Cycle 0 is the negedge on entry; cycle n is sampled n negedges later.
    task automatic run(input bit start, input int dly,
                       input logic [NSRC-1:0] late, input int budget);
        int c;
        int hold;
        bit p_bus_ack;
        bit p_cpu_ack;
        bit p_cpu;
        logic [VW-1:0] held;
        vec_q.delete();
        vec_cyc.delete();
        ack_cyc.delete();
        rd_q.delete();
        wr_base = wr_q.size();
        c = 0;
        hold = 0;
        p_bus_ack = 0;
        p_cpu_ack = 0;
        p_cpu = 0;
        held = '0;
        irq_i = start;
        while (1) begin
            @(negedge clk);
            c++;
            irq_i = 1'b0;
            src_pulse = '0;
            cpu_ack_i = 1'b0;
            if (p_bus_ack) check("bus_gap", o_wb_cyc, 0);
            if (p_cpu_ack) begin
                check("rescan_cyc", o_wb_cyc, 1);
                check("cpu_irq_drop", cpu_irq_o, 0);
            end
            p_bus_ack = o_wb_cyc && s_ack;
            if (o_wb_cyc && !o_wb_we && s_ack)
                rd_q.push_back({o_wb_adr, rdt});
            if (irq_ack_o) ack_cyc.push_back(c);
            p_cpu_ack = 0;
            if (cpu_irq_o) begin
                if (!p_cpu) begin
                    vec_q.push_back(cpu_vec_o);
                    vec_cyc.push_back(c);
                    held = cpu_vec_o;
                    hold = 0;
                    src_pulse = late;
                    late = '0;
                end else begin
                    check("vec_stable", cpu_vec_o, held);
                end
                if (hold >= dly) begin
                    cpu_ack_i = 1'b1;
                    p_cpu_ack = 1;
                end
                hold++;
            end
            p_cpu = cpu_irq_o;
            if (!busy_o && c > 1) break;
            if (c >= budget) begin
                total++;
                assert (busy_o === 1'b0) else begin
                    bad++;
                    $error("FAIL run_budget busy=%0b exp=0", busy_o);
                end
                break;
            end
        end
    endtask

    task automatic outs_zero(input string tag);
        check(tag, {irq_ack_o, o_wb_cyc, o_wb_adr, o_wb_we, o_wb_dat,
                    cpu_irq_o, cpu_vec_o, busy_o, err_o}, 0);
    endtask

    initial begin
        logic [NSRC-1:0] st;
        logic [NSRC-1:0] ie;
        logic [NSRC-1:0] cur;
        logic [NSRC-1:0] e_wr[$];
        int              e_vec[$];
        int              c;
        int              n;

        rst = 1'b1;
        irq_i = 1'b0;
        cpu_ack_i = 1'b0;
        src_pulse = '0;
        s_clr = 1'b0;
        s_hang = 1'b0;
        s_ie = '0;
        repeat (3) @(negedge clk);
        outs_zero("reset_outs");
        rst = 1'b0;
        @(negedge clk);
        outs_zero("post_reset_outs");

        // Single source int3.
        s_ie = 8'h04;
        pulse_src(8'h04);
        run(1, 0, '0, 200);
        check("ss_nack", ack_cyc.size(), 2);
        check("ss_ack0_cyc", ack_cyc[0], 10);
        check("ss_ack1_cyc", ack_cyc[1], 18);
        check("ss_nvec", vec_q.size(), 1);
        check("ss_vec", vec_q[0], 2);
        check("ss_vec_cyc", vec_cyc[0], 11);
        check("ss_nwr", wr_q.size() - wr_base, 1);
        check("ss_wr", wr_q[wr_base], 8'h00);
        check("ss_nrd", rd_q.size(), 4);
        check("ss_rd0", rd_q[0], 9'h004);
        check("ss_rd1", rd_q[1], 9'h104);
        check("ss_rd2", rd_q[2], 9'h000);
        check("ss_rd3", rd_q[3], 9'h104);
        check("ss_idle", busy_o, 0);

        // Priority and drain.
        clear_status();
        s_ie = 8'hFF;
        pulse_src(8'h05);
        run(1, 2, '0, 200);
        check("pr_nvec", vec_q.size(), 2);
        check("pr_vec0", vec_q[0], 0);
        check("pr_vec1", vec_q[1], 2);
        check("pr_nwr", wr_q.size() - wr_base, 2);
        check("pr_wr0", wr_q[wr_base], 8'h04);
        check("pr_wr1", wr_q[wr_base + 1], 8'h00);
        check("pr_nack", ack_cyc.size(), 3);

        // Masked source.
        clear_status();
        s_ie = 8'h00;
        pulse_src(8'h10);
        run(1, 0, '0, 200);
        check("mk_nvec", vec_q.size(), 0);
        check("mk_nwr", wr_q.size() - wr_base, 0);
        check("mk_nack", ack_cyc.size(), 1);
        check("mk_ack_cyc", ack_cyc[0], 7);
        check("mk_status", s_st, 8'h10);

        // Late edge on int2 while vector 0 is presented.
        clear_status();
        s_ie = 8'h03;
        pulse_src(8'h01);
        run(1, 3, 8'h02, 200);
        check("le_nvec", vec_q.size(), 2);
        check("le_vec0", vec_q[0], 0);
        check("le_vec1", vec_q[1], 1);
        check("le_nwr", wr_q.size() - wr_base, 2);
        check("le_wr1", wr_q[wr_base + 1], 8'h00);
        check("le_nack", ack_cyc.size(), 3);

        // Randomized: vectors in ascending bit order of status & IE.
        for (int t = 0; t < 20; t++) begin
            st = NSRC'($urandom_range(0, 255));
            ie = NSRC'($urandom_range(0, 255));
            e_vec.delete();
            e_wr.delete();
            cur = st;
            for (int b = 0; b < NSRC; b++) begin
                if (st[b] && ie[b]) begin
                    e_vec.push_back(b);
                    cur[b] = 1'b0;
                    e_wr.push_back(cur);
                end
            end
            clear_status();
            s_ie = ie;
            pulse_src(st);
            run(1, $urandom_range(0, 3), '0, 400);
            check("rnd_nvec", vec_q.size(), e_vec.size());
            for (int i = 0; i < e_vec.size() && i < vec_q.size(); i++)
                check("rnd_vec", vec_q[i], e_vec[i]);
            check("rnd_nwr", wr_q.size() - wr_base, e_wr.size());
            for (int i = 0; i < e_wr.size() &&
                            i < wr_q.size() - wr_base; i++)
                check("rnd_wr", wr_q[wr_base + i], e_wr[i]);
            check("rnd_nack", ack_cyc.size(), e_vec.size() + 1);
            check("rnd_final", s_st, st & ~ie);
            check("rnd_err", err_o, 0);
            if (e_vec.size() > 0) check("rnd_vcyc", vec_cyc[0], 11);
        end

        // Timeout: slave never acks while int stays high.
        clear_status();
        s_hang = 1'b1;
        irq_i = 1'b1;
        n = 0;
        for (c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c <= 16) n += o_wb_cyc ? 1 : 0;
            if (c == 16) check("to_err_before", err_o, 0);
            if (c == 17) begin
                check("to_cyc_drop", o_wb_cyc, 0);
                check("to_err", err_o, 1);
            end
            if (c == 18) check("to_retry", o_wb_cyc, 1);
        end
        check("to_cyc_count", n, 16);
        s_hang = 1'b0;
        irq_i = 1'b0;
        c = 0;
        while (busy_o && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("to_recover", busy_o, 0);
        check("to_sticky", err_o, 1);

        // Asynchronous reset in the middle of WR_ST.
        clear_status();
        s_ie = 8'h01;
        pulse_src(8'h01);
        irq_i = 1'b1;
        c = 0;
        while (!o_wb_we && c < 40) begin
            @(negedge clk);
            irq_i = 1'b0;
            c++;
        end
        check("ar_in_wr", o_wb_we, 1);
        #2 rst = 1'b1;
        #1 outs_zero("ar_outs");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ar_idle", busy_o, 0);
        @(negedge clk);
        check("ar_no_retry", o_wb_cyc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_dispatch.md
# int_dispatch

Hardware interrupt dispatcher that sits between the 8-source interrupt controller and the CPU core. On the controller's `int` request it acts as Wishbone master on the controller's register port. It reads the status and enable registers, selects the highest-priority pending source, clears that status bit, and pulses the controller's acknowledge. It then presents a vector to the CPU and rescans until no enabled source is pending.

## Interface
Parameters:
- `NSRC`, 8, source count; equals the controller data-bus width.
- `VW`, 3, vector width, equal to clog2(`NSRC`).
- `WB_TIMEOUT`, 16, maximum number of `o_wb_cyc` cycles to wait for `i_wb_ack` before aborting.

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `irq_i`, in, 1, controller `int` output.
- `irq_ack_o`, out, 1, one-cycle pulse to the controller `ins_ack`.
- `o_wb_cyc`, out, 1, bus cycle request.
- `o_wb_adr`, out, 1, register select: 0 = status, 1 = IE.
- `o_wb_we`, out, 1, write enable.
- `o_wb_dat`, out, `NSRC`, write data.
- `i_wb_rdt`, in, `NSRC`, read data.
- `i_wb_ack`, in, 1, slave acknowledge.
- `cpu_irq_o`, out, 1, vector valid to the CPU.
- `cpu_vec_o`, out, `VW`, source index; 0 = int1.
- `cpu_ack_i`, in, 1, CPU accepted the vector.
- `busy_o`, out, 1, FSM is not in IDLE.
- `err_o`, out, 1, sticky bus-timeout flag; cleared only by `rst`.

## Operation
- FSM states, in order: IDLE → RD_ST → GAP1 → RD_IE → GAP2 → PICK → WR_ST → ACKI → PRESENT.
- IDLE: `irq_i`=1 → RD_ST.
- RD_ST: `cyc`=1, `adr`=0, `we`=0. On `i_wb_ack`, latch `st`=`i_wb_rdt` and go to GAP1.
- GAP1 and GAP2: `cyc`=0 for exactly one cycle. This is mandatory between transactions because the slave toggles its ack.
- RD_IE: `adr`=1. On ack, latch `ie` and go to GAP2.
- PICK: compute `pend` = `st` & `ie`.
  - `pend`=0: pulse `irq_ack_o` and go to IDLE (spurious or drained case). No write is issued.
  - `pend`≠0: `idx` = lowest set bit (int1 has highest priority); go to WR_ST.
- WR_ST: `cyc`=1, `we`=1, `adr`=0, `o_wb_dat` = `st` & ~(1<<`idx`). On ack, go to ACKI.
- ACKI: `irq_ack_o`=1 for one cycle, `cyc`=0; go to PRESENT.
- PRESENT: `cpu_irq_o`=1 and `cpu_vec_o`=`idx`, both held stable until `cpu_ack_i`. On `cpu_ack_i`, drop `cpu_irq_o` and go to RD_ST (rescan). A rescan never goes directly to IDLE.
- Rescan catches sources whose edges were ignored while the controller's `int` was high. The loop ends via the PICK `pend`=0 path.
- `irq_i` is ignored outside IDLE.
- Timeout: a counter runs while `cyc`=1 and `i_wb_ack`=0. On reaching `WB_TIMEOUT`: `cyc`→0, `err_o`→1, state→IDLE. If `irq_i` is still high, the sequence retries.
- Known limitation: a source edge arriving after the RD_ST ack but before the WR_ST ack cycle is overwritten by the write-back. The window is 6 cycles with a 1-cycle slave.
- `busy_o` = (state ≠ IDLE).
- `cpu_ack_i` outside PRESENT is ignored.

## Timing
- Reset values: all outputs are 0 and the state is IDLE. Assertion of `rst` mid-transaction drops `cyc`/`we` immediately; a partial write is not retried.
- All outputs are registered.
- Reference timeline with a 1-cycle slave, taking `irq_i`=1 sampled in cycle 0:
  - RD_ST `cyc` in cycles 1–2, ack in cycle 2.
  - GAP1 in cycle 3.
  - RD_IE in cycles 4–5.
  - GAP2 in cycle 6.
  - PICK in cycle 7.
  - WR_ST in cycles 8–9; the write commits at the end of cycle 9.
  - `irq_ack_o` in cycle 10.
  - `cpu_irq_o` first high in cycle 11.
- Rescan: `cpu_ack_i` seen in cycle k → RD_ST `cyc` in cycle k+1.
- The timeout fires in the cycle where the count reaches `WB_TIMEOUT` (16 `cyc` cycles without ack); `cyc` is 0 in the next cycle.

## Test plan
- Reset: assert `rst` asynchronously mid-WR_ST → every output is 0 in the same cycle and the FSM is in IDLE after release.
- Single source: IE=0x04, pulse int3 → reads return status 0x04 and IE 0x04; write 0x00; `irq_ack_o` in cycle 10; `cpu_vec_o`=2 with `cpu_irq_o` in cycle 11. After `cpu_ack_i`, the rescan reads 0x00, `irq_ack_o` pulses, and the FSM returns to IDLE.
- Priority and drain: IE=0xFF, status 0x05 → vector 0 first with write 0x04. After `cpu_ack_i`, vector 2 with write 0x00, then IDLE.
- Masked source: status 0x10, IE 0x00, `irq_i`=1 → no write, `irq_ack_o` pulse, `cpu_irq_o` stays 0.
- Timeout: slave never acks → `cyc` drops after 16 cycles, `err_o`=1 sticky, and the sequence retries while `irq_i`=1.
- Late edge: int2 rises while PRESENT holds vector 0 → the rescan delivers vector 1 without a new controller `int`.
